// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
//
// The cache sits between the core's memory-access stage and a word-wide
// backing memory. A load miss fills the whole line, word 0 first. Stores
// always go through to memory, and they update the cached copy only on a hit.
// Byte, half and word accesses are supported. Load results are sign- or
// zero-extended. Misaligned accesses are answered with resp_err and have no
// other effect.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req_*        core request (valid/ready handshake, we, addr, width, uns, wdata)
//   resp_*       one-cycle completion pulse with load data and error flag
//   mem_*        backing-memory word port (req held until ack)
//   hit_cnt      load hits since reset (wraps)
//   miss_cnt     load misses since reset (wraps)
module dcache_dm #(
  parameter logic [31:0] ADDR_BASE      = 32'h1001_0000,
  parameter int          LINES          = 16,
  parameter int          WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_uns,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int AW = IB + WB;            // word pointer into the data array
  localparam int TB = 32 - 2 - AW;        // tag width
  localparam int NW = LINES * WORDS_PER_LINE;
  localparam logic [31:0]   LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
  localparam logic [AW-1:0] WORD_MASK = AW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

  state_t            state_q;
  logic [LINES-1:0]  valid_q;
  logic [TB-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [NW];

  // Latched request context for the multi-cycle paths.
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     fill_ptr_q;
  logic [IB-1:0]     idx_q;
  logic [1:0]        lane_q;
  logic [1:0]        width_q;
  logic              uns_q;

  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;

  // Address decode of the base-relative offset.
  logic [31:0]       off;
  logic [AW-1:0]     ptr;
  logic [IB-1:0]     idx;
  logic [TB-1:0]     tag;

  assign off = req_addr - ADDR_BASE;
  assign ptr = off[AW+1:2];
  assign idx = off[AW+1:WB+2];
  assign tag = off[31:AW+2];

  logic hit;
  logic misaligned;
  logic accept;
  logic ack;
  logic fill_last;
  logic tag_we;

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign misaligned = ((req_width == 2'b01) && req_addr[0]) ||
                      (req_width[1] && (req_addr[1:0] != 2'b00));
  // An ack is only meaningful while a transfer is outstanding.
  assign ack        = mem_ack && mem_req_q;
  assign fill_last  = (fill_ptr_q & WORD_MASK) == WORD_MASK;
  assign tag_we     = accept && !misaligned && !req_we && !hit;

  // Store data replicated across lanes so the strobe alone selects bytes.
  logic [31:0] st_data;
  logic [3:0]  st_strb;

  always_comb begin
    st_data = req_wdata;
    st_strb = 4'b1111;
    case (req_width)
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_strb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_strb = 4'b0011 << req_addr[1:0];
      end
      default: begin
        st_data = req_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  // The word being written on the final fill ack is not in the array yet.
  logic [31:0] fill_word;
  assign fill_word = (fill_ptr_q == ptr_q) ? mem_rdata : data_q[ptr_q];

  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [1:0]  lane,
                                         input logic [1:0]  width,
                                         input logic        uns);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    case (width)
      2'b00:   extend = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extend = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Data array write port: store hits (per strobe) and fill words.
  logic [3:0]    arr_bwe;
  logic [AW-1:0] arr_ptr;
  logic [31:0]   arr_wdata;

  always_comb begin
    arr_bwe   = 4'b0000;
    arr_ptr   = ptr;
    arr_wdata = st_data;
    if (!rst) begin
      if (accept && !misaligned && req_we && hit) begin
        arr_bwe = st_strb;
      end else if ((state_q == S_FILL) && ack) begin
        arr_bwe   = 4'b1111;
        arr_ptr   = fill_ptr_q;
        arr_wdata = mem_rdata;
      end
    end
  end

  // Data and tag storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (arr_bwe[b]) begin
        data_q[arr_ptr][b*8 +: 8] <= arr_wdata[b*8 +: 8];
      end
    end
    if (tag_we) begin
      tag_q[idx] <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      ptr_q        <= '0;
      fill_ptr_q   <= '0;
      idx_q        <= '0;
      lane_q       <= 2'b00;
      width_q      <= 2'b00;
      uns_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'b0000;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ptr_q   <= ptr;
            idx_q   <= idx;
            lane_q  <= req_addr[1:0];
            width_q <= req_width;
            uns_q   <= req_uns;
            if (misaligned) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we) begin
              if (hit) begin
                resp_valid_q <= 1'b1;
                resp_rdata_q <= extend(data_q[ptr], req_addr[1:0], req_width, req_uns);
                hit_cnt_q    <= hit_cnt_q + 32'd1;
              end else begin
                miss_cnt_q   <= miss_cnt_q + 32'd1;
                valid_q[idx] <= 1'b0;
                state_q      <= S_FILL;
                mem_req_q    <= 1'b1;
                mem_we_q     <= 1'b0;
                mem_wdata_q  <= '0;
                mem_wstrb_q  <= 4'b0000;
                mem_addr_q   <= ADDR_BASE + (off & ~LINE_MASK);
                fill_ptr_q   <= ptr & ~WORD_MASK;
              end
            end else begin
              state_q     <= S_WRITE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ADDR_BASE + (off & ~32'd3);
              mem_wdata_q <= st_data;
              mem_wstrb_q <= st_strb;
            end
          end
        end

        S_FILL: begin
          if (ack) begin
            fill_ptr_q <= fill_ptr_q + AW'(1);
            mem_addr_q <= mem_addr_q + 32'd4;
            if (fill_last) begin
              valid_q[idx_q] <= 1'b1;
              mem_req_q      <= 1'b0;
              state_q        <= S_RESP;
              resp_valid_q   <= 1'b1;
              resp_rdata_q   <= extend(fill_word, lane_q, width_q, uns_q);
            end
          end
        end

        S_WRITE: begin
          if (ack) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wstrb_q  <= 4'b0000;
            resp_valid_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed self-checking bench for dcache_dm.
// A background responder models the backing memory: it acks each transfer
// after two wait cycles, applies strobed writes to its model, and logs the
// read addresses.
module tb_dcache_dm;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_uns;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_dm #(.ADDR_BASE(BASE), .LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_width(req_width), .req_uns(req_uns),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Responder state
  logic [31:0] mem_model [1024];
  logic [31:0] rd_log [$];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic        last_we    = 1'b0;

  // Monitor state
  int resp_cnt   = 0;
  int req_cycles = 0;

  initial begin
    int wcnt;
    logic [9:0] mi;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0000_1000 + 32'(i);
    mem_model[0] = 32'h0000_00A0;
    mem_model[1] = 32'h0000_00A1;
    mem_model[2] = 32'h0000_00A2;
    mem_model[3] = 32'h0000_00A3;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        wcnt++;
        if (wcnt > 2) begin
          wcnt    = 0;
          mem_ack = 1'b1;
          mi      = 10'((mem_addr - BASE) >> 2);
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem_model[mi][b*8 +: 8] = mem_wdata[b*8 +: 8];
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            last_wstrb = mem_wstrb;
            last_we    = mem_we;
            wr_cnt++;
          end else begin
            mem_rdata = mem_model[mi];
            rd_log.push_back(mem_addr);
            rd_cnt++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
      if (mem_req) req_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] width,
                        input logic uns, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_width = width;
    req_uns   = uns;
    req_wdata = wdata;
    req_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_ready_wait", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] rd, output logic er, output int lat);
    lat = -1;
    rd  = 'x;
    er  = 1'bx;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd  = resp_rdata;
        er  = resp_err;
        lat = n;
        break;
      end
    end
    #1;
    check("resp_wait", 32'(lat > 0), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          snap;
  logic        ok;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_width = 2'b00;
    req_uns   = 1'b0;
    req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load miss with line fill, then a hit in the same line
    do_req(1'b0, 32'h1001_0000, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0000, rd, er, lat);
    check("miss_rdata", rd, 32'h0000_00A0);
    check("miss_err", 32'(er), 32'd0);
    check("miss_cnt_1", miss_cnt, 32'd1);
    check("miss_hit_cnt", hit_cnt, 32'd0);
    check("fill_reads", 32'(rd_cnt), 32'd4);
    check("fill_addr0", rd_log[0], 32'h1001_0000);
    check("fill_addr1", rd_log[1], 32'h1001_0004);
    check("fill_addr2", rd_log[2], 32'h1001_0008);
    check("fill_addr3", rd_log[3], 32'h1001_000C);

    do_req(1'b0, 32'h1001_0004, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0004, rd, er, lat);
    check("hit_rdata", rd, 32'h0000_00A1);
    check("hit_lat", 32'(lat), 32'd1);
    check("hit_cnt_1", hit_cnt, 32'd1);
    check("hit_no_mem", 32'(rd_cnt), 32'd4);

    // Word store on hit gives the line 0x000080F0 in word 0
    do_req(1'b1, 32'h1001_0000, 2'b10, 1'b0, 32'h0000_80F0);
    wait_resp(rd, er, lat);
    $display("store %h <- %h err=%0d lat=%0d", 32'h1001_0000, 32'h0000_80F0, er, lat);
    check("stw_rdata", rd, 32'd0);
    check("stw_err", 32'(er), 32'd0);
    check("stw_wr_cnt", 32'(wr_cnt), 32'd1);
    check("stw_addr", last_waddr, 32'h1001_0000);
    check("stw_wdata", last_wdata, 32'h0000_80F0);
    check("stw_wstrb", 32'(last_wstrb), 32'hF);
    check("stw_we", 32'(last_we), 32'd1);

    // Extension cases on the hit path
    do_req(1'b0, 32'h1001_0000, 2'b00, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0000, rd, er, lat);
    check("lb_s0", rd, 32'hFFFF_FFF0);
    do_req(1'b0, 32'h1001_0001, 2'b00, 1'b1, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0001, rd, er, lat);
    check("lbu_1", rd, 32'h0000_0080);
    do_req(1'b0, 32'h1001_0000, 2'b01, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0000, rd, er, lat);
    check("lh_s0", rd, 32'hFFFF_80F0);
    do_req(1'b0, 32'h1001_0001, 2'b00, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0001, rd, er, lat);
    check("lb_s1", rd, 32'hFFFF_FF80);
    do_req(1'b0, 32'h1001_0002, 2'b01, 1'b1, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0002, rd, er, lat);
    check("lhu_2", rd, 32'h0000_0000);
    check("ext_hit_cnt", hit_cnt, 32'd6);
    check("ext_no_mem", 32'(rd_cnt), 32'd4);

    // Byte store on hit
    do_req(1'b1, 32'h1001_0002, 2'b00, 1'b0, 32'h1234_565A);
    wait_resp(rd, er, lat);
    $display("store %h <- %h err=%0d lat=%0d", 32'h1001_0002, 32'h1234_565A, er, lat);
    check("stb_wstrb", 32'(last_wstrb), 32'h4);
    check("stb_wdata", last_wdata, 32'h5A5A_5A5A);
    check("stb_addr", last_waddr, 32'h1001_0000);
    check("stb_we", 32'(last_we), 32'd1);
    check("stb_rdata", rd, 32'd0);
    do_req(1'b0, 32'h1001_0000, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0000, rd, er, lat);
    check("stb_reload", rd, 32'h005A_80F0);
    check("stb_reload_lat", 32'(lat), 32'd1);
    check("stb_no_fill", 32'(rd_cnt), 32'd4);

    // Half store on hit, upper half of word 1
    do_req(1'b1, 32'h1001_0006, 2'b01, 1'b0, 32'h7777_BEEF);
    wait_resp(rd, er, lat);
    $display("store %h <- %h err=%0d lat=%0d", 32'h1001_0006, 32'h7777_BEEF, er, lat);
    check("sth_wstrb", 32'(last_wstrb), 32'hC);
    check("sth_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sth_addr", last_waddr, 32'h1001_0004);
    do_req(1'b0, 32'h1001_0006, 2'b01, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0006, rd, er, lat);
    check("sth_lh", rd, 32'hFFFF_BEEF);
    do_req(1'b0, 32'h1001_0004, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0004, rd, er, lat);
    check("sth_lw", rd, 32'hBEEF_00A1);
    check("sth_hit_cnt", hit_cnt, 32'd9);

    // Store to an uncached line: write only, then the load misses
    do_req(1'b1, 32'h1001_0040, 2'b10, 1'b0, 32'h1234_5678);
    wait_resp(rd, er, lat);
    $display("store %h <- %h err=%0d lat=%0d", 32'h1001_0040, 32'h1234_5678, er, lat);
    check("nwa_no_fill", 32'(rd_cnt), 32'd4);
    check("nwa_wr_cnt", 32'(wr_cnt), 32'd4);
    check("nwa_addr", last_waddr, 32'h1001_0040);
    do_req(1'b0, 32'h1001_0040, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0040, rd, er, lat);
    check("nwa_rdata", rd, 32'h1234_5678);
    check("nwa_miss_cnt", miss_cnt, 32'd2);
    check("nwa_fill", 32'(rd_cnt), 32'd8);
    do_req(1'b0, 32'h1001_0040, 2'b11, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0040, rd, er, lat);
    check("w11_rdata", rd, 32'h1234_5678);
    check("w11_hit_cnt", hit_cnt, 32'd10);

    // Misaligned accesses
    snap = req_cycles;
    do_req(1'b0, 32'h1001_0001, 2'b01, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0001, rd, er, lat);
    check("mis_h_err", 32'(er), 32'd1);
    check("mis_h_rdata", rd, 32'd0);
    check("mis_h_lat", 32'(lat), 32'd1);
    do_req(1'b0, 32'h1001_0002, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0002, rd, er, lat);
    check("mis_w_err", 32'(er), 32'd1);
    check("mis_w_rdata", rd, 32'd0);
    do_req(1'b1, 32'h1001_0003, 2'b01, 1'b0, 32'hFFFF_FFFF);
    wait_resp(rd, er, lat);
    $display("store %h <- %h err=%0d lat=%0d", 32'h1001_0003, 32'hFFFF_FFFF, er, lat);
    check("mis_s_err", 32'(er), 32'd1);
    @(posedge clk);
    #1;
    check("mis_no_mem_req", 32'(req_cycles - snap), 32'd0);
    check("mis_hit_cnt", hit_cnt, 32'd10);
    check("mis_miss_cnt", miss_cnt, 32'd2);
    check("mis_wr_cnt", 32'(wr_cnt), 32'd4);

    // Reset in the middle of a fill
    do_req(1'b0, 32'h1001_0080, 2'b10, 1'b0, '0);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (rd_cnt >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_wait", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("reset during fill: mem_req=%0d resp_valid=%0d", mem_req, resp_valid);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_hit_cnt", hit_cnt, 32'd0);
    check("abort_miss_cnt", miss_cnt, 32'd0);
    rst  = 1'b0;
    snap = resp_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_resp", 32'(resp_cnt - snap), 32'd0);
    check("abort_idle_mem", 32'(mem_req), 32'd0);
    check("abort_reads", 32'(rd_cnt), 32'd10);

    do_req(1'b0, 32'h1001_0080, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0080, rd, er, lat);
    check("refill_rdata", rd, 32'h0000_1020);
    check("refill_miss_cnt", miss_cnt, 32'd1);
    check("refill_reads", 32'(rd_cnt), 32'd14);
    check("refill_addr0", rd_log[10], 32'h1001_0080);
    check("refill_addr3", rd_log[13], 32'h1001_008C);

    do_req(1'b0, 32'h1001_0000, 2'b10, 1'b0, '0);
    wait_resp(rd, er, lat);
    $display("load  %h -> %h err=%0d lat=%0d", 32'h1001_0000, rd, er, lat);
    check("post_rst_rdata", rd, 32'h005A_80F0);
    check("post_rst_miss_cnt", miss_cnt, 32'd2);
    check("post_rst_reads", 32'(rd_cnt), 32'd18);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
